// File: rtl/window_peak_detector_if.sv
// Sample stream in, per-window result out, for window_peak_detector.
// slave is the detector's side; master is the source/sink side.
interface window_peak_detector_if #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
);
    localparam int IW = $clog2(WINDOW);
    localparam int CW = $clog2(WINDOW);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IW-1:0]    out_idx;
    logic [CW-1:0]    out_rises;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_max,
        output out_idx,
        output out_rises
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_max,
        input  out_idx,
        input  out_rises
    );
endinterface

// File: rtl/window_peak_detector.sv
// Groups samples into fixed windows and reports each window's peak,
// the index of the peak's first occurrence, and its count of strict rises.
module window_peak_detector #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    window_peak_detector_if.slave bus
);
    localparam int IW = $clog2(WINDOW);
    localparam int CW = $clog2(WINDOW);
    localparam logic [IW-1:0] LAST = IW'(WINDOW - 1);

    typedef enum logic {ACCUM, REPORT} state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    count;
    logic [WIDTH-1:0] run_max;
    logic [IW-1:0]    run_idx;
    logic [CW-1:0]    run_rises;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] max_reg;
    logic [IW-1:0]    idx_reg;
    logic [CW-1:0]    rises_reg;

    logic             accept;
    logic             last_sample;
    logic [WIDTH-1:0] max_next;
    logic [IW-1:0]    idx_next;
    logic [CW-1:0]    rises_next;

    // Ready is a function of state and reset only, never of in_valid.
    assign bus.in_ready  = rst_n & (state == ACCUM);
    assign bus.out_valid = (state == REPORT);
    assign bus.out_max   = max_reg;
    assign bus.out_idx   = idx_reg;
    assign bus.out_rises = rises_reg;

    assign accept      = bus.in_valid & bus.in_ready;
    assign last_sample = accept & (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (last_sample)   state_next = REPORT;
            REPORT:  if (bus.out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Running statistics including the sample being accepted this cycle;
    // ties never displace the stored peak, so the earliest index wins.
    always_comb begin
        max_next   = run_max;
        idx_next   = run_idx;
        rises_next = run_rises;
        if (count == '0) begin
            max_next   = bus.in_data;
            idx_next   = '0;
            rises_next = '0;
        end else begin
            if (bus.in_data > run_max) begin
                max_next = bus.in_data;
                idx_next = count;
            end
            if (bus.in_data > prev) begin
                rises_next = run_rises + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            run_rises <= '0;
            prev      <= '0;
        end else if (accept) begin
            run_max   <= max_next;
            run_idx   <= idx_next;
            run_rises <= rises_next;
            prev      <= bus.in_data;
            count     <= last_sample ? '0 : count + IW'(1);
        end
    end

    // Result registers hold the last report until the next window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg   <= '0;
            idx_reg   <= '0;
            rises_reg <= '0;
        end else if (last_sample) begin
            max_reg   <= max_next;
            idx_reg   <= idx_next;
            rises_reg <= rises_next;
        end
    end
endmodule

// File: tb/tb_window_peak_detector.sv
// Directed bench for window_peak_detector: expected window results go into a
// queue and a negedge monitor compares them whenever a result is taken.
module tb_window_peak_detector;
    localparam int WIDTH  = 4;
    localparam int WINDOW = 8;

    typedef struct packed {
        logic [3:0] max;
        logic [2:0] idx;
        logic [2:0] rises;
    } result_t;

    logic    clk;
    logic    rst_n;
    int      checks;
    int      errors;
    result_t expq[$];
    logic [3:0] win [8];

    window_peak_detector_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

    window_peak_detector #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Result monitor: a transfer happens at the next posedge when both are high.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result actual=%0d/%0d/%0d expected=none",
                         bus.out_max, bus.out_idx, bus.out_rises);
            end else begin
                result_t e;
                e = expq.pop_front();
                checkOutput("result_max",   int'(bus.out_max),   int'(e.max));
                checkOutput("result_idx",   int'(bus.out_idx),   int'(e.idx));
                checkOutput("result_rises", int'(bus.out_rises), int'(e.rises));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one sample and hold it until accepted; leaves time at posedge+1.
    task automatic applyStimulus(input logic [3:0] data);
        bit got;
        int waited;
        got = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!got) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!got && waited > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
                got = 1'b1;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends win[0..7]; maxGap > 0 inserts 1..maxGap bubble cycles between samples.
    task automatic sendWindow(input logic [3:0] emax, input logic [2:0] eidx,
                              input logic [2:0] erises, input int maxGap);
        expq.push_back('{max: emax, idx: eidx, rises: erises});
        for (int i = 0; i < 8; i++) begin
            applyStimulus(win[i]);
            if (maxGap > 0 && i < 7) idleCycles(int'($urandom_range(1, maxGap)));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_out_valid", int'(bus.out_valid), 1);
        checkOutput("report_in_ready",   int'(bus.in_ready),  0);
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("reset_out_valid", int'(bus.out_valid), 0);
            checkOutput("reset_out_max",   int'(bus.out_max),   0);
            checkOutput("reset_out_idx",   int'(bus.out_idx),   0);
            checkOutput("reset_out_rises", int'(bus.out_rises), 0);
            checkOutput("reset_in_ready",  int'(bus.in_ready),  0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        win = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd15, 4'd0};
        sendWindow(4'd15, 3'd6, 3'd3, 0);

        win = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        sendWindow(4'd5, 3'd0, 3'd0, 0);

        win = '{4'd9, 4'd1, 4'd9, 4'd1, 4'd9, 4'd1, 4'd9, 4'd1};
        sendWindow(4'd9, 3'd0, 3'd3, 0);

        // Backpressure: result must hold and junk input must not be consumed.
        bus.out_ready = 1'b0;
        win = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd15, 4'd0};
        sendWindow(4'd15, 3'd6, 3'd3, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_data  = 4'($urandom);
            @(negedge clk);
            checkOutput("hold_out_valid", int'(bus.out_valid), 1);
            checkOutput("hold_out_max",   int'(bus.out_max),   15);
            checkOutput("hold_out_idx",   int'(bus.out_idx),   6);
            checkOutput("hold_out_rises", int'(bus.out_rises), 3);
            checkOutput("hold_in_ready",  int'(bus.in_ready),  0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("drop_out_valid",   int'(bus.out_valid), 0);
        checkOutput("drop_in_ready",    int'(bus.in_ready),  1);
        checkOutput("retained_out_max", int'(bus.out_max),   15);
        @(posedge clk);
        #1;

        win = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        sendWindow(4'd7, 3'd7, 3'd7, 0);

        win = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd15, 4'd0};
        sendWindow(4'd15, 3'd6, 3'd3, 3);

        // Partial window discarded by an asynchronous reset pulse.
        applyStimulus(4'd15);
        applyStimulus(4'd14);
        applyStimulus(4'd13);
        applyStimulus(4'd12);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        win = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        sendWindow(4'd8, 3'd7, 3'd7, 0);

        idleCycles(4);
        checkOutput("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
